// File: rtl/mux_sel_nway.sv
// N-channel W-bit multiplexer stepped by debounced push-buttons, with an
// optional auto-scan mode. Select, data and change pulse are all registered.

module mux_sel_nway_debounce #(
  parameter int LIMIT = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic press
);
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          stable_prev_q, stable_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d       = sw_raw;
    sync2_d       = sync1_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    cnt_d         = '0;
    // Any sample that matches the stable value restarts the count.
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(LIMIT - 1)) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      cnt_q         <= cnt_d;
    end
  end

  assign press = stable_q & ~stable_prev_q;
endmodule

module mux_sel_nway #(
  parameter int WIDTH          = 4,
  parameter int NUM_CH         = 4,
  parameter int SEL_W          = 2,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int AUTO_PERIOD    = 25000000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Switch_Next,
  input  logic                    i_Switch_Prev,
  input  logic                    i_Switch_Mode,
  input  logic [NUM_CH*WIDTH-1:0] i_Data,
  output logic [WIDTH-1:0]        o_Data,
  output logic [SEL_W-1:0]        o_Sel,
  output logic                    o_Auto,
  output logic                    o_Change
);
  localparam int NUM_SW = 3;
  localparam int TW     = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  logic [NUM_SW-1:0] sw_raw;
  logic [NUM_SW-1:0] press;

  assign sw_raw = {i_Switch_Mode, i_Switch_Prev, i_Switch_Next};

  for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
    mux_sel_nway_debounce #(.LIMIT(DEBOUNCE_LIMIT)) u_db (
      .clk    (i_Clk),
      .rst    (i_Rst),
      .sw_raw (sw_raw[g]),
      .press  (press[g])
    );
  end

  logic             next_ev, prev_ev, mode_ev;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             auto_q, auto_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             change_q, change_d;
  logic             step_fwd, step_back, auto_step;

  assign next_ev = press[0];
  assign prev_ev = press[1];
  assign mode_ev = press[2];

  always_comb begin
    auto_d    = mode_ev ? ~auto_q : auto_q;
    timer_d   = '0;
    auto_step = 1'b0;
    // Mode press and any manual press restart the scan period; no auto step then.
    if (auto_q && !mode_ev && !(next_ev || prev_ev)) begin
      if (timer_q == TW'(AUTO_PERIOD - 1)) auto_step = 1'b1;
      else                                 timer_d   = timer_q + TW'(1);
    end

    step_fwd  = (next_ev & ~prev_ev) | auto_step;
    step_back = prev_ev & ~next_ev;

    sel_d = sel_q;
    if (step_fwd)
      sel_d = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + SEL_W'(1);
    else if (step_back)
      sel_d = (sel_q == '0) ? SEL_W'(NUM_CH - 1) : sel_q - SEL_W'(1);

    change_d = (sel_d != sel_q);

    data_d = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (sel_q == SEL_W'(k)) data_d = i_Data[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sel_q    <= '0;
      auto_q   <= 1'b0;
      timer_q  <= '0;
      data_q   <= '0;
      change_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      auto_q   <= auto_d;
      timer_q  <= timer_d;
      data_q   <= data_d;
      change_q <= change_d;
    end
  end

  assign o_Sel    = sel_q;
  assign o_Auto   = auto_q;
  assign o_Data   = data_q;
  assign o_Change = change_q;
endmodule

// File: tb/tb_mux_sel_nway.sv
// Directed bench for mux_sel_nway: 3 channels, debounce 4, auto period 8.

module tb_mux_sel_nway;
  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b0;
  logic        i_Switch_Next = 1'b0;
  logic        i_Switch_Prev = 1'b0;
  logic        i_Switch_Mode = 1'b0;
  logic [11:0] i_Data = 12'hCBA;
  logic [3:0]  o_Data;
  logic [1:0]  o_Sel;
  logic        o_Auto;
  logic        o_Change;

  int tests = 0;
  int fails = 0;
  int chg_total = 0;

  mux_sel_nway #(
    .WIDTH(4), .NUM_CH(3), .SEL_W(2), .DEBOUNCE_LIMIT(4), .AUTO_PERIOD(8)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_Switch_Next(i_Switch_Next), .i_Switch_Prev(i_Switch_Prev),
    .i_Switch_Mode(i_Switch_Mode), .i_Data(i_Data),
    .o_Data(o_Data), .o_Sel(o_Sel), .o_Auto(o_Auto), .o_Change(o_Change)
  );

  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) if (o_Change === 1'b1) chg_total++;

  task automatic step();
    @(posedge i_Clk); #1;
  endtask

  task automatic apply_reset();
    i_Switch_Next = 0; i_Switch_Prev = 0; i_Switch_Mode = 0;
    i_Rst = 1; step(); step(); i_Rst = 0;
  endtask

  // Press a switch (0=next 1=prev 2=mode) for hold cycles, then idle gap cycles.
  task automatic pulse(input int which, input int hold, input int gap);
    case (which)
      0: i_Switch_Next = 1;
      1: i_Switch_Prev = 1;
      default: i_Switch_Mode = 1;
    endcase
    repeat (hold) step();
    i_Switch_Next = 0; i_Switch_Prev = 0; i_Switch_Mode = 0;
    repeat (gap) step();
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (o_Sel !== 2'd0 || o_Auto !== 1'b0 || o_Data !== 4'h0 || o_Change !== 1'b0) begin
      fails++;
      $display("FAIL reset: sel=%0d auto=%b data=%h chg=%b, want 0 0 0 0", o_Sel, o_Auto, o_Data, o_Change);
    end
  endtask

  task automatic test_single_next();
    int base;
    apply_reset();
    base = chg_total;
    i_Switch_Next = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      tests++;
      if (o_Sel !== ((k >= 7) ? 2'd1 : 2'd0) || o_Change !== (k == 7) ||
          o_Data !== ((k >= 8) ? 4'hB : 4'hA)) begin
        fails++;
        $display("FAIL single_next edge %0d: sel=%0d chg=%b data=%h", k, o_Sel, o_Change, o_Data);
      end
    end
    i_Switch_Next = 0;
    repeat (10) step();
    tests++;
    if (o_Sel !== 2'd1 || chg_total - base !== 1) begin
      fails++;
      $display("FAIL single_next_once: sel=%0d changes=%0d, want 1 1", o_Sel, chg_total - base);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [3];
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(0, 8, 8);
      tests++;
      if (o_Sel !== exp_seq[i]) begin
        fails++;
        $display("FAIL wrap_next %0d: sel=%0d want %0d", i, o_Sel, exp_seq[i]);
      end
    end
    pulse(1, 8, 8);
    tests++;
    if (o_Sel !== 2'd2) begin
      fails++;
      $display("FAIL wrap_prev: sel=%0d want 2", o_Sel);
    end
  endtask

  task automatic test_bounce();
    int base;
    apply_reset();
    base = chg_total;
    for (int i = 0; i < 12; i++) begin
      i_Switch_Next = (i % 2 == 0);
      step();
    end
    i_Switch_Next = 0;
    repeat (10) step();
    tests++;
    if (o_Sel !== 2'd0 || chg_total != base) begin
      fails++;
      $display("FAIL bounce: sel=%0d changes=%0d, want 0 0", o_Sel, chg_total - base);
    end
    pulse(0, 3, 10);
    tests++;
    if (o_Sel !== 2'd0 || chg_total != base) begin
      fails++;
      $display("FAIL short_pulse: sel=%0d changes=%0d, want 0 0", o_Sel, chg_total - base);
    end
    pulse(0, 6, 10);
    tests++;
    if (o_Sel !== 2'd1 || chg_total - base !== 1) begin
      fails++;
      $display("FAIL long_pulse: sel=%0d changes=%0d, want 1 1", o_Sel, chg_total - base);
    end
  endtask

  task automatic test_both();
    int base;
    apply_reset();
    base = chg_total;
    i_Switch_Next = 1; i_Switch_Prev = 1;
    repeat (20) step();
    i_Switch_Next = 0; i_Switch_Prev = 0;
    repeat (10) step();
    tests++;
    if (o_Sel !== 2'd0 || chg_total != base) begin
      fails++;
      $display("FAIL both_pressed: sel=%0d changes=%0d, want 0 0", o_Sel, chg_total - base);
    end
  endtask

  task automatic test_auto();
    int base;
    int n;
    apply_reset();
    i_Switch_Mode = 1;
    n = 0;
    while (o_Auto !== 1'b1 && n < 20) begin step(); n++; end
    i_Switch_Mode = 0;
    tests++;
    if (n != 7) begin
      fails++;
      $display("FAIL auto_enter: entered after %0d edges, want 7 (auto=%b)", n, o_Auto);
    end
    for (int i = 1; i <= 24; i++) begin
      step();
      tests++;
      if (o_Sel !== 2'((i / 8) % 3) || o_Change !== (i % 8 == 0)) begin
        fails++;
        $display("FAIL auto_scan cycle %0d: sel=%0d chg=%b want %0d", i, o_Sel, o_Change, (i / 8) % 3);
      end
    end
    i_Switch_Prev = 1;
    for (int k = 1; k <= 7; k++) begin
      step();
      tests++;
      if (o_Sel !== ((k == 7) ? 2'd2 : 2'd0)) begin
        fails++;
        $display("FAIL auto_prev edge %0d: sel=%0d", k, o_Sel);
      end
    end
    i_Switch_Prev = 0;
    for (int j = 1; j <= 8; j++) begin
      step();
      tests++;
      if (o_Sel !== ((j == 8) ? 2'd0 : 2'd2)) begin
        fails++;
        $display("FAIL auto_after_prev cycle %0d: sel=%0d", j, o_Sel);
      end
    end
    i_Switch_Mode = 1;
    repeat (7) step();
    i_Switch_Mode = 0;
    tests++;
    if (o_Auto !== 1'b0 || o_Sel !== 2'd0) begin
      fails++;
      $display("FAIL auto_exit: auto=%b sel=%0d, want 0 0", o_Auto, o_Sel);
    end
    base = chg_total;
    repeat (30) step();
    tests++;
    if (o_Sel !== 2'd0 || chg_total != base || o_Auto !== 1'b0) begin
      fails++;
      $display("FAIL auto_stopped: sel=%0d changes=%0d auto=%b", o_Sel, chg_total - base, o_Auto);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    apply_reset();
    i_Switch_Mode = 1;
    n = 0;
    while (o_Auto !== 1'b1 && n < 20) begin step(); n++; end
    i_Switch_Mode = 0;
    repeat (16) step();
    tests++;
    if (o_Auto !== 1'b1 || o_Sel !== 2'd2) begin
      fails++;
      $display("FAIL reset_mid_setup: auto=%b sel=%0d, want 1 2", o_Auto, o_Sel);
    end
    i_Switch_Next = 1;
    repeat (3) step();
    i_Rst = 1; step(); i_Rst = 0;
    tests++;
    if (o_Sel !== 2'd0 || o_Auto !== 1'b0 || o_Data !== 4'h0 || o_Change !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: sel=%0d auto=%b data=%h chg=%b", o_Sel, o_Auto, o_Data, o_Change);
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      tests++;
      if (o_Sel !== ((k >= 7) ? 2'd1 : 2'd0) || o_Change !== (k == 7) || o_Auto !== 1'b0) begin
        fails++;
        $display("FAIL reset_held_press edge %0d: sel=%0d chg=%b auto=%b", k, o_Sel, o_Change, o_Auto);
      end
    end
    i_Switch_Next = 0;
    repeat (10) step();
  endtask

  initial begin
    #1;
    test_reset();
    test_single_next();
    test_wrap();
    test_bounce();
    test_both();
    test_auto();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
